rbt_s_vlan_deparser: RTL and testbench
======================================

RBT_S_VLAN_DEPARSER -- requirements
Module: rbt_s_vlan_deparser

Interface
REQ-001 SHALL have parameter HEADER_WIDTH, default 2048, header bus width in bits; multiple of 8; byte 0 at bits [HEADER_WIDTH-1 -: 8].
REQ-002 SHALL have parameter PKT_METADATA_WIDTH, default 272, metadata bus width in bits; minimum 261.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_proto_hdr_valid  input  1  input beat valid.
REQ-006 in_proto_hdr_ready  output  1  input beat accepted when valid&ready.
REQ-007 in_proto_hdr_length  input  16  header length in bytes.
REQ-008 in_proto_hdr_data  input  HEADER_WIDTH  header bytes, starting at destination MAC.
REQ-009 in_proto_hdr_pkt_metadata  input  PKT_METADATA_WIDTH  packet metadata.
REQ-010 out_proto_hdr_valid / out_proto_hdr_ready  output / input  1 each  output handshake.
REQ-011 out_proto_hdr_length / _data / _pkt_metadata  output  16 / HEADER_WIDTH / PKT_METADATA_WIDTH  processed beat.
REQ-012 cfg_insert_en  input  1  tag insertion enable.
REQ-013 cfg_pcp  input  3  priority code point for the inserted tag.
REQ-014 cfg_dei  input  1  drop eligible indicator for the inserted tag.
REQ-015 cfg_vid  input  12  VLAN ID for the inserted tag.
REQ-016 stat_inserted_cnt, stat_bypass_cnt, stat_oversize_cnt  output  32 each  event counters.

Function
REQ-017 Metadata fields: PROTO bits [40 +: 32], VLAN flag at bit 41; IP_OFFSET [236 +: 5]; SEATL_OFFSET [252 +: 9].
REQ-018 cfg_* inputs SHALL be sampled on the accepting cycle only.
REQ-019 Insert condition: cfg_insert_en=1, VLAN flag=0, and in_length <= HEADER_WIDTH/8 - 4.
REQ-020 On insert, output data SHALL be: bytes 0-11 = input bytes 0-11; bytes 12-13 = 16'h8100; bytes 14-15 = {pcp, dei, vid}; byte 16 onward = input byte 12 onward; the last 4 input bytes are dropped.
REQ-021 On insert, out_length = in_length + 4.
REQ-022 On insert, VLAN flag SHALL be set to 1.
REQ-023 On insert, IP_OFFSET += 4 modulo 32 and SEATL_OFFSET += 4 modulo 512; all other metadata bits pass through unchanged.
REQ-024 When no insert occurs, data, length and metadata SHALL pass through unmodified.
REQ-025 Counters, incremented once per accepted beat, wrapping at 2^32:
- inserted: beat took the insert path;
- bypass: cfg_insert_en=0 or VLAN flag=1;
- oversize: cfg_insert_en=1, flag=0, length too large.
REQ-026 Latency SHALL be exactly 1 cycle from accept to out_valid when the output is empty.
REQ-027 Throughput SHALL be 1 beat/cycle under continuous out_ready=1.
REQ-028 The output stage SHALL be a 2-entry skid buffer (main register plus skid register).
- in_proto_hdr_ready SHALL be registered, equal to NOT skid_valid, with no combinational path from out_proto_hdr_ready.
REQ-029 Skid states: EMPTY, ONE (main only), FULL (main+skid).
- EMPTY -> ONE on accept.
- ONE -> ONE on accept and pop together.
- ONE -> FULL on accept without pop.
- ONE -> EMPTY on pop only.
- FULL -> ONE on pop; the skid entry moves to main.
REQ-030 Order SHALL be preserved; no beat is dropped or duplicated under any valid/ready pattern.
REQ-031 Output payload SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-032 When rst=1, the block SHALL go to state EMPTY.
REQ-033 When rst=1, out_proto_hdr_valid=0, in_proto_hdr_ready=0.
REQ-034 When rst=1, the data, length, metadata and counter registers SHALL be 0.
REQ-035 in_proto_hdr_ready SHALL return to 1 in the first cycle after rst deasserts.
REQ-036 Reset mid-operation SHALL discard all buffered beats, with no partial output afterward.

Structure
REQ-037 A shared package SHALL hold:
- the metadata field positions and widths (PROTO, VLAN_TAG_INDEX=1, IPV6_TAG_INDEX=4, IP_OFFSET, SEATL_OFFSET);
- the TPID constant 16'h8100;
- the VLAN tag length 4.
REQ-038 The skid buffer SHALL be one sub-module, rbt_hdr_skid_buffer, parameterised by payload width; the insert datapath stays in the top module.

Verification
REQ-039 Scenario 1: insert_en=1, flag=0, length=64, pcp=5, dei=0, vid=0x123 -> out bytes 12-15 = 81 00 A1 23, byte 16 = input byte 12, length 68, IP_OFFSET+4, SEATL+4, flag=1, inserted_cnt=1.
REQ-040 Scenario 2: VLAN flag=1 input -> bit-exact passthrough, bypass_cnt=1; then insert_en=0 -> passthrough, bypass_cnt=2.
REQ-041 Scenario 3: length=HEADER_WIDTH/8-3 with insert_en=1 -> passthrough, oversize_cnt=1; length=HEADER_WIDTH/8-4 -> inserted.
REQ-042 Scenario 4: IP_OFFSET=30, SEATL=510 -> outputs 2 and 2 (wrap).
REQ-043 Scenario 5: 100 beats with random in_valid and out_ready at 50% each -> in-order, lossless, payload stable while stalled, in_ready never 1 when FULL.
REQ-044 Scenario 6: rst asserted with buffer FULL -> next cycle out_valid=0 and counters=0; a beat sent after reset appears alone, 1 cycle later.

Source files
------------

// File: rtl/rbt_s_vlan_deparser_pkg.sv
// Shared constants for the S-VLAN deparser: metadata field layout, tag constants, skid states.
package rbt_s_vlan_deparser_pkg;

  localparam int unsigned PROTO_LSB          = 40;
  localparam int unsigned PROTO_WIDTH        = 32;
  localparam int unsigned VLAN_TAG_INDEX     = 1;
  localparam int unsigned IPV6_TAG_INDEX     = 4;
  localparam int unsigned VLAN_FLAG_BIT      = PROTO_LSB + VLAN_TAG_INDEX;
  localparam int unsigned IP_OFFSET_LSB      = 236;
  localparam int unsigned IP_OFFSET_WIDTH    = 5;
  localparam int unsigned SEATL_OFFSET_LSB   = 252;
  localparam int unsigned SEATL_OFFSET_WIDTH = 9;

  localparam logic [15:0] TPID         = 16'h8100;
  localparam int unsigned VLAN_TAG_LEN = 4;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} skid_state_e;

  function automatic logic [15:0] vlan_tci(input logic [2:0] pcp, input logic dei,
                                           input logic [11:0] vid);
    return {pcp, dei, vid};
  endfunction

endpackage

// File: rtl/rbt_s_vlan_deparser_if.sv
// Protocol-header beat bus: valid/ready handshake carrying length, header bytes and metadata.
interface rbt_s_vlan_deparser_if #(
  parameter int unsigned HEADER_WIDTH       = 2048,
  parameter int unsigned PKT_METADATA_WIDTH = 272
) ();
  import rbt_s_vlan_deparser_pkg::*;

  logic                          valid;
  logic                          ready;
  logic [15:0]                   length;
  logic [HEADER_WIDTH-1:0]       data;
  logic [PKT_METADATA_WIDTH-1:0] pkt_metadata;

  modport master (output valid, length, data, pkt_metadata, input ready);
  modport slave  (input valid, length, data, pkt_metadata, output ready);

endinterface

// File: rtl/rbt_hdr_skid_buffer.sv
// Two-entry registered skid buffer; upstream ready is a flop, never combinational from downstream.
module rbt_hdr_skid_buffer
  import rbt_s_vlan_deparser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  skid_state_e      r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_in_valid & r_in_ready;
  assign w_pop  = r_out_valid & i_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          r_in_ready <= 1'b1;
          if (w_push) begin
            r_main      <= i_in_data;
            r_out_valid <= 1'b1;
            r_state     <= StOne;
          end
        end
        StOne: begin
          r_in_ready <= 1'b1;
          if (w_push && w_pop) begin
            r_main <= i_in_data;
          end else if (w_push) begin
            r_skid     <= i_in_data;
            r_in_ready <= 1'b0;
            r_state    <= StFull;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= StEmpty;
          end
        end
        StFull: begin
          // Upstream is stalled here, so only a pop can move us.
          if (w_pop) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= StOne;
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_main;

endmodule

// File: rtl/rbt_s_vlan_deparser.sv
// Inserts an 802.1Q tag after the MAC addresses when enabled and untagged, then skid-buffers the beat.
module rbt_s_vlan_deparser
  import rbt_s_vlan_deparser_pkg::*;
#(
  parameter int unsigned HEADER_WIDTH       = 2048,
  parameter int unsigned PKT_METADATA_WIDTH = 272
) (
  input  logic                         clk,
  input  logic                         rst,
  rbt_s_vlan_deparser_if.slave         in_proto_hdr,
  rbt_s_vlan_deparser_if.master        out_proto_hdr,
  input  logic                         cfg_insert_en,
  input  logic [2:0]                   cfg_pcp,
  input  logic                         cfg_dei,
  input  logic [11:0]                  cfg_vid,
  output logic [31:0]                  stat_inserted_cnt,
  output logic [31:0]                  stat_bypass_cnt,
  output logic [31:0]                  stat_oversize_cnt
);

  localparam int unsigned     HdrBytes  = HEADER_WIDTH / 8;
  localparam logic [15:0]     MaxInsLen = 16'(HdrBytes - VLAN_TAG_LEN);
  localparam int unsigned     KeepBits  = 12 * 8;
  localparam int unsigned     TailBits  = HEADER_WIDTH - KeepBits - 8 * VLAN_TAG_LEN;
  localparam int unsigned     PayloadW  = 16 + HEADER_WIDTH + PKT_METADATA_WIDTH;

  logic                          w_accept;
  logic                          w_flag;
  logic                          w_fits;
  logic                          w_do_insert;
  logic                          w_bypass;
  logic                          w_oversize;
  logic [15:0]                   w_len;
  logic [HEADER_WIDTH-1:0]       w_data;
  logic [PKT_METADATA_WIDTH-1:0] w_md;
  logic [PayloadW-1:0]           w_out_payload;
  logic [31:0]                   r_inserted_cnt;
  logic [31:0]                   r_bypass_cnt;
  logic [31:0]                   r_oversize_cnt;

  assign w_accept    = in_proto_hdr.valid & in_proto_hdr.ready;
  assign w_flag      = in_proto_hdr.pkt_metadata[VLAN_FLAG_BIT];
  assign w_fits      = in_proto_hdr.length <= MaxInsLen;
  assign w_do_insert = cfg_insert_en & ~w_flag & w_fits;
  assign w_bypass    = ~cfg_insert_en | w_flag;
  assign w_oversize  = cfg_insert_en & ~w_flag & ~w_fits;

  always_comb begin
    w_len  = in_proto_hdr.length;
    w_data = in_proto_hdr.data;
    w_md   = in_proto_hdr.pkt_metadata;
    if (w_do_insert) begin
      // The tag shifts everything after the MACs by 4 bytes; the last 4 header bytes fall off.
      w_data = {in_proto_hdr.data[HEADER_WIDTH-1 -: KeepBits], TPID,
                vlan_tci(cfg_pcp, cfg_dei, cfg_vid),
                in_proto_hdr.data[HEADER_WIDTH-KeepBits-1 -: TailBits]};
      w_len  = in_proto_hdr.length + 16'(VLAN_TAG_LEN);
      w_md[VLAN_FLAG_BIT] = 1'b1;
      w_md[IP_OFFSET_LSB +: IP_OFFSET_WIDTH] =
        in_proto_hdr.pkt_metadata[IP_OFFSET_LSB +: IP_OFFSET_WIDTH] +
        IP_OFFSET_WIDTH'(VLAN_TAG_LEN);
      w_md[SEATL_OFFSET_LSB +: SEATL_OFFSET_WIDTH] =
        in_proto_hdr.pkt_metadata[SEATL_OFFSET_LSB +: SEATL_OFFSET_WIDTH] +
        SEATL_OFFSET_WIDTH'(VLAN_TAG_LEN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inserted_cnt <= '0;
      r_bypass_cnt   <= '0;
      r_oversize_cnt <= '0;
    end else if (w_accept) begin
      if (w_do_insert) r_inserted_cnt <= r_inserted_cnt + 32'd1;
      if (w_bypass)    r_bypass_cnt   <= r_bypass_cnt + 32'd1;
      if (w_oversize)  r_oversize_cnt <= r_oversize_cnt + 32'd1;
    end
  end

  rbt_hdr_skid_buffer #(
    .WIDTH (PayloadW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_proto_hdr.valid),
    .o_in_ready  (in_proto_hdr.ready),
    .i_in_data   ({w_len, w_data, w_md}),
    .o_out_valid (out_proto_hdr.valid),
    .i_out_ready (out_proto_hdr.ready),
    .o_out_data  (w_out_payload)
  );

  assign {out_proto_hdr.length, out_proto_hdr.data, out_proto_hdr.pkt_metadata} = w_out_payload;

  assign stat_inserted_cnt = r_inserted_cnt;
  assign stat_bypass_cnt   = r_bypass_cnt;
  assign stat_oversize_cnt = r_oversize_cnt;

endmodule

// File: tb/tb_rbt_s_vlan_deparser.sv
// Bench for rbt_s_vlan_deparser: directed vector table, random handshake stress, mid-run reset.
module tb_rbt_s_vlan_deparser;
  import rbt_s_vlan_deparser_pkg::*;

  localparam int unsigned HW = 2048;
  localparam int unsigned MW = 272;
  localparam int unsigned NB = HW / 8;
  localparam int unsigned PW = 16 + HW + MW;

  typedef logic [HW-1:0] data_t;
  typedef logic [MW-1:0] md_t;
  typedef logic [PW-1:0] pl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_insert_en = 1'b0;
  logic [2:0]  cfg_pcp = '0;
  logic        cfg_dei = 1'b0;
  logic [11:0] cfg_vid = '0;
  logic [31:0] stat_inserted_cnt, stat_bypass_cnt, stat_oversize_cnt;

  rbt_s_vlan_deparser_if #(.HEADER_WIDTH(HW), .PKT_METADATA_WIDTH(MW)) in_if ();
  rbt_s_vlan_deparser_if #(.HEADER_WIDTH(HW), .PKT_METADATA_WIDTH(MW)) out_if ();

  rbt_s_vlan_deparser #(
    .HEADER_WIDTH       (HW),
    .PKT_METADATA_WIDTH (MW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_proto_hdr      (in_if.slave),
    .out_proto_hdr     (out_if.master),
    .cfg_insert_en     (cfg_insert_en),
    .cfg_pcp           (cfg_pcp),
    .cfg_dei           (cfg_dei),
    .cfg_vid           (cfg_vid),
    .stat_inserted_cnt (stat_inserted_cnt),
    .stat_bypass_cnt   (stat_bypass_cnt),
    .stat_oversize_cnt (stat_oversize_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_ins = 0, exp_byp = 0, exp_ovs = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_pl(input string name, input pl_t act, input pl_t exp);
    int first;
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      first = -1;
      for (int i = PW - 1; i >= 0; i--) if (first < 0 && act[i] !== exp[i]) first = i;
      $display("FAIL %s: payload differs at bit %0d (got %b want %b)", name, first,
               act[first], exp[first]);
    end
  endtask

  function automatic pl_t out_pl();
    return {out_if.length, out_if.data, out_if.pkt_metadata};
  endfunction

  function automatic data_t make_data(input int seed);
    data_t d;
    for (int i = 0; i < NB; i++) d[HW-1-8*i -: 8] = 8'((i * 7 + seed) & 255);
    return d;
  endfunction

  function automatic data_t rand_data();
    data_t d;
    for (int w = 0; w < HW / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic md_t rand_md();
    logic [287:0] t;
    for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom();
    return t[MW-1:0];
  endfunction

  // Byte-level reference: kind 0 = insert, 1 = bypass, 2 = oversize.
  function automatic void model(input data_t d, input logic [15:0] len, input md_t md,
                                input logic en, input logic [2:0] pcp, input logic dei,
                                input logic [11:0] vid, output pl_t pl, output int kind);
    data_t       od;
    logic [15:0] ol;
    md_t         om;
    od = d; ol = len; om = md;
    if (!en || md[41]) kind = 1;
    else if (len > 16'(NB - 4)) kind = 2;
    else kind = 0;
    if (kind == 0) begin
      for (int b = 0; b < NB; b++) begin
        if (b < 12)       od[HW-1-8*b -: 8] = d[HW-1-8*b -: 8];
        else if (b == 12) od[HW-1-8*b -: 8] = 8'h81;
        else if (b == 13) od[HW-1-8*b -: 8] = 8'h00;
        else if (b == 14) od[HW-1-8*b -: 8] = {pcp, dei, vid[11:8]};
        else if (b == 15) od[HW-1-8*b -: 8] = vid[7:0];
        else              od[HW-1-8*b -: 8] = d[HW-1-8*(b-4) -: 8];
      end
      ol = len + 16'd4;
      om[41] = 1'b1;
      om[236 +: 5] = md[236 +: 5] + 5'd4;
      om[252 +: 9] = md[252 +: 9] + 9'd4;
    end
    pl = {ol, od, om};
  endfunction

  function automatic void count_kind(input int kind);
    if (kind == 0) exp_ins++;
    else if (kind == 1) exp_byp++;
    else exp_ovs++;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_ins_cnt"}, stat_inserted_cnt, exp_ins);
    chk({tag, "_byp_cnt"}, stat_bypass_cnt, exp_byp);
    chk({tag, "_ovs_cnt"}, stat_oversize_cnt, exp_ovs);
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  pcp;
    logic        dei;
    logic [11:0] vid;
    logic [15:0] len;
    logic        flag;
    logic [4:0]  ip;
    logic [8:0]  seatl;
    int          kind;
    logic [15:0] exp_len;
    logic [4:0]  exp_ip;
    logic [8:0]  exp_seatl;
    logic        exp_flag;
    logic [31:0] exp_b12;
  } vec_t;

  vec_t vecs[7];

  initial begin
    pl_t   exp_pl, hold_pl, prev_pl;
    pl_t   q[$];
    md_t   md;
    data_t d;
    int    kind, occ, sent, recv, cyc;
    logic  holding, stalled_prev;
    logic [15:0] cur_len;
    logic  cur_en, cur_dei;
    logic [2:0] cur_pcp;
    logic [11:0] cur_vid;

    vecs[0] = '{1'b1, 3'd5, 1'b0, 12'h123, 16'd64,  1'b0, 5'd3,  9'd20,  0,
                16'd68,  5'd7,  9'd24,  1'b1, 32'h8100A123};
    vecs[1] = '{1'b1, 3'd0, 1'b0, 12'h000, 16'd64,  1'b1, 5'd3,  9'd20,  1,
                16'd64,  5'd3,  9'd20,  1'b1, 32'h555C636A};
    vecs[2] = '{1'b0, 3'd7, 1'b1, 12'hFFF, 16'd100, 1'b0, 5'd10, 9'd100, 1,
                16'd100, 5'd10, 9'd100, 1'b0, 32'h565D646B};
    vecs[3] = '{1'b1, 3'd1, 1'b0, 12'h001, 16'd253, 1'b0, 5'd0,  9'd0,   2,
                16'd253, 5'd0,  9'd0,   1'b0, 32'h575E656C};
    vecs[4] = '{1'b1, 3'd2, 1'b1, 12'hABC, 16'd252, 1'b0, 5'd1,  9'd1,   0,
                16'd256, 5'd5,  9'd5,   1'b1, 32'h81005ABC};
    vecs[5] = '{1'b1, 3'd3, 1'b0, 12'h456, 16'd100, 1'b0, 5'd30, 9'd510, 0,
                16'd104, 5'd2,  9'd2,   1'b1, 32'h81006456};
    vecs[6] = '{1'b1, 3'd7, 1'b1, 12'hFFF, 16'd0,   1'b0, 5'd31, 9'd511, 0,
                16'd4,   5'd3,  9'd3,   1'b1, 32'h8100FFFF};

    in_if.valid = 1'b0;
    in_if.length = '0;
    in_if.data = '0;
    in_if.pkt_metadata = '0;
    out_if.ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_if.valid, 1'b0);
    chk("rst_in_ready", in_if.ready, 1'b0);
    chk_pl("rst_payload", out_pl(), '0);
    chk_counters("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_if.ready, 1'b1);

    // Directed table
    for (int k = 0; k < 7; k++) begin
      md = rand_md();
      md[41] = vecs[k].flag;
      md[236 +: 5] = vecs[k].ip;
      md[252 +: 9] = vecs[k].seatl;
      d = make_data(k);
      in_if.data = d;
      in_if.length = vecs[k].len;
      in_if.pkt_metadata = md;
      cfg_insert_en = vecs[k].en;
      cfg_pcp = vecs[k].pcp;
      cfg_dei = vecs[k].dei;
      cfg_vid = vecs[k].vid;
      in_if.valid = 1'b1;
      model(d, vecs[k].len, md, vecs[k].en, vecs[k].pcp, vecs[k].dei, vecs[k].vid, exp_pl, kind);
      count_kind(vecs[k].kind);
      chk($sformatf("v%0d_in_ready", k), in_if.ready, 1'b1);
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
      // Changing cfg after the accept must not disturb the captured beat.
      cfg_insert_en = ~cfg_insert_en;
      cfg_vid = ~cfg_vid;
      chk($sformatf("v%0d_kind", k), kind, vecs[k].kind);
      chk($sformatf("v%0d_out_valid", k), out_if.valid, 1'b1);
      chk($sformatf("v%0d_len", k), out_if.length, vecs[k].exp_len);
      chk($sformatf("v%0d_b12_15", k), out_if.data[HW-97 -: 32], vecs[k].exp_b12);
      chk($sformatf("v%0d_flag", k), out_if.pkt_metadata[41], vecs[k].exp_flag);
      chk($sformatf("v%0d_ip_off", k), out_if.pkt_metadata[236 +: 5], vecs[k].exp_ip);
      chk($sformatf("v%0d_seatl", k), out_if.pkt_metadata[252 +: 9], vecs[k].exp_seatl);
      chk_pl($sformatf("v%0d_payload", k), out_pl(), exp_pl);
      chk_counters($sformatf("v%0d", k));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_drained", k), out_if.valid, 1'b0);
    end

    // Random valid/ready stress
    occ = 0; sent = 0; recv = 0; holding = 1'b0; stalled_prev = 1'b0;
    prev_pl = '0; hold_pl = '0; cur_len = '0;
    for (cyc = 0; cyc < 3000 && recv < 100; cyc++) begin
      @(posedge clk);
      #1;
      if (!holding && sent < 100) begin
        md = rand_md();
        d = rand_data();
        cur_len = 16'($urandom_range(0, 300));
        cur_en = 1'($urandom_range(0, 3) != 0);
        cur_pcp = 3'($urandom());
        cur_dei = 1'($urandom());
        cur_vid = 12'($urandom());
        in_if.data = d;
        in_if.length = cur_len;
        in_if.pkt_metadata = md;
        model(d, cur_len, md, cur_en, cur_pcp, cur_dei, cur_vid, hold_pl, kind);
        holding = 1'b1;
      end
      cfg_insert_en = cur_en;
      cfg_pcp = cur_pcp;
      cfg_dei = cur_dei;
      cfg_vid = cur_vid;
      in_if.valid = holding && ($urandom_range(0, 1) == 1);
      out_if.ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      chk("rnd_in_ready", in_if.ready, occ < 2);
      chk("rnd_out_valid", out_if.valid, occ > 0);
      if (stalled_prev) chk_pl("rnd_stall_stable", out_pl(), prev_pl);
      if (out_if.valid && out_if.ready) begin
        if (q.size() == 0) chk("rnd_unexpected_pop", 1'b1, 1'b0);
        else chk_pl($sformatf("rnd_beat%0d", recv), out_pl(), q.pop_front());
        occ--;
        recv++;
      end
      stalled_prev = out_if.valid && !out_if.ready;
      prev_pl = out_pl();
      if (in_if.valid && in_if.ready) begin
        q.push_back(hold_pl);
        count_kind(kind);
        occ++;
        sent++;
        holding = 1'b0;
      end
    end
    chk("rnd_all_received", recv, 100);
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    chk_counters("rnd");

    // Reset with the buffer full
    out_if.ready = 1'b0;
    cfg_insert_en = 1'b0;
    in_if.data = make_data(40);
    in_if.valid = 1'b1;
    @(posedge clk);
    #1;
    in_if.data = make_data(41);
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    chk("full_in_ready", in_if.ready, 1'b0);
    chk("full_out_valid", out_if.valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_ins = 0; exp_byp = 0; exp_ovs = 0;
    chk("mid_rst_out_valid", out_if.valid, 1'b0);
    chk("mid_rst_in_ready", in_if.ready, 1'b0);
    chk_counters("mid_rst");
    rst = 1'b0;
    out_if.ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_rst_in_ready", in_if.ready, 1'b1);
    chk("after_rst_no_stale", out_if.valid, 1'b0);
    md = rand_md();
    md[41] = 1'b0;
    d = make_data(50);
    in_if.data = d;
    in_if.length = 16'd80;
    in_if.pkt_metadata = md;
    cfg_insert_en = 1'b1;
    cfg_pcp = 3'd4;
    cfg_dei = 1'b1;
    cfg_vid = 12'h3C5;
    model(d, 16'd80, md, 1'b1, 3'd4, 1'b1, 12'h3C5, exp_pl, kind);
    count_kind(kind);
    in_if.valid = 1'b1;
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    chk("after_rst_beat_valid", out_if.valid, 1'b1);
    chk_pl("after_rst_beat", out_pl(), exp_pl);
    chk("after_rst_tci", out_if.data[HW-97 -: 32], 32'h8100_93C5);
    @(posedge clk);
    #1;
    chk("after_rst_alone", out_if.valid, 1'b0);
    chk_counters("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
